// File: rtl/chan_out_arbiter_pkg.sv
// rtl/chan_out_arbiter_pkg.sv - shared widths, config address map, FSM states and saturation helper
// Purpose: single source of the channel/data widths, config register addresses and
//          the signed saturation used when pipeline results are buffered.
// Ports:   none (package).
package chan_out_arbiter_pkg;

    localparam int N_CHAN    = 5;
    localparam int W_CHAN    = 5;
    localparam int W_DIN     = 64;
    localparam int W_DOUT    = 16;
    localparam int W_WR_ADDR = 16;
    localparam int W_WR_DATA = 48;

    localparam logic [W_WR_ADDR-1:0] ADDR_EN   = 16'h0040;
    localparam logic [W_WR_ADDR-1:0] ADDR_OVFC = 16'h0041;

    // Saturation bounds expressed at the input width so comparisons stay signed.
    localparam logic signed [W_DIN-1:0] SAT_MAX = W_DIN'((64'sd1 <<< (W_DOUT - 1)) - 64'sd1);
    localparam logic signed [W_DIN-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

    function automatic logic [W_DOUT-1:0] sat(input logic signed [W_DIN-1:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[W_DOUT-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[W_DOUT-1:0];
        end else begin
            return x[W_DOUT-1:0];
        end
    endfunction

endpackage

// File: rtl/chan_out_arbiter_if.sv
// rtl/chan_out_arbiter_if.sv - pipeline ingest, config write and DAC output signals of the arbiter
// Purpose: bundles every non-clock signal of chan_out_arbiter.
// Ports:   slave modport (the arbiter) takes dv_in/chan_in/data_in, wr_en/wr_addr/wr_data
//          and rdy_in, and drives dv_out/chan_out/data_out/ovf_out; master is the mirror.
interface chan_out_arbiter_if import chan_out_arbiter_pkg::*; ();

    logic                 dv_in;
    logic [W_CHAN-1:0]    chan_in;
    logic [W_DIN-1:0]     data_in;
    logic                 wr_en;
    logic [W_WR_ADDR-1:0] wr_addr;
    logic [W_WR_DATA-1:0] wr_data;
    logic                 rdy_in;
    logic                 dv_out;
    logic [W_CHAN-1:0]    chan_out;
    logic [W_DOUT-1:0]    data_out;
    logic [N_CHAN-1:0]    ovf_out;

    modport slave (
        input  dv_in, chan_in, data_in, wr_en, wr_addr, wr_data, rdy_in,
        output dv_out, chan_out, data_out, ovf_out
    );

    modport master (
        output dv_in, chan_in, data_in, wr_en, wr_addr, wr_data, rdy_in,
        input  dv_out, chan_out, data_out, ovf_out
    );

endinterface

// File: rtl/chan_out_arbiter_rr_arbiter.sv
// rtl/chan_out_arbiter_rr_arbiter.sv - combinational round-robin picker
// Purpose: grants the first requesting channel after the last granted one, wrapping mod N.
// Ports:   req (N request bits), last (index of previous grant) in;
//          gnt (one-hot), idx (granted index), any (some request present) out.
module rr_arbiter import chan_out_arbiter_pkg::*; #(
    parameter int N = N_CHAN,
    parameter int W = W_CHAN
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    // Offsets 1..N from the last grant; the previous winner is therefore checked last.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && req[j] && (j == (int'(last) + k) % N)) begin
                    any    = 1'b1;
                    gnt[j] = 1'b1;
                    idx    = W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/chan_out_arbiter.sv
// rtl/chan_out_arbiter.sv - coalescing per-channel result buffer with round-robin DAC output
// Purpose: keeps the newest saturated pipeline result per channel, flags overwrites of
//          unsent values, and forwards pending enabled channels one at a time.
// Ports:   clk_in, rst_in (sync active-low) plain; bus (slave modport) carries ingest,
//          config write and the dv_out/rdy_in output handshake plus ovf_out flags.
module chan_out_arbiter import chan_out_arbiter_pkg::*; (
    input  logic                      clk_in,
    input  logic                      rst_in,
    chan_out_arbiter_if.slave         bus
);

    arb_state_t        state_q;
    arb_state_t        state_nxt;

    logic [W_DOUT-1:0] data_buf [N_CHAN];
    logic [N_CHAN-1:0] pend;
    logic [N_CHAN-1:0] ovf;
    logic [N_CHAN-1:0] en;
    logic [W_CHAN-1:0] rr;

    logic [N_CHAN-1:0] ingest_hit;
    logic [W_DOUT-1:0] sat_data;
    logic [N_CHAN-1:0] gnt;
    logic [W_CHAN-1:0] gnt_idx;
    logic              gnt_any;
    logic [W_DOUT-1:0] sel_data;
    logic              load;
    logic              en_wr;
    logic              ovfc_wr;

    assign sat_data = sat(bus.data_in);
    assign en_wr    = bus.wr_en && (bus.wr_addr == ADDR_EN);
    assign ovfc_wr  = bus.wr_en && (bus.wr_addr == ADDR_OVFC);
    assign bus.ovf_out = ovf;

    // Out-of-range channel numbers match no bit and are silently dropped.
    always_comb begin
        ingest_hit = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            ingest_hit[i] = bus.dv_in && (bus.chan_in == W_CHAN'(i));
        end
    end

    rr_arbiter #(
        .N (N_CHAN),
        .W (W_CHAN)
    ) u_rr (
        .req  (pend & en),
        .last (rr),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (gnt[i]) begin
                sel_data = sel_data | data_buf[i];
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    load      = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.rdy_in) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            bus.dv_out   <= 1'b0;
            bus.chan_out <= '0;
            bus.data_out <= '0;
            pend         <= '0;
            ovf          <= '0;
            en           <= '0;
            rr           <= W_CHAN'(N_CHAN - 1);
            for (int i = 0; i < N_CHAN; i++) begin
                data_buf[i] <= '0;
            end
        end else begin
            state_q <= state_nxt;

            if (load) begin
                bus.chan_out <= gnt_idx;
                bus.data_out <= sel_data;
                bus.dv_out   <= 1'b1;
                rr           <= gnt_idx;
            end else if (state_q == ST_SEND && bus.rdy_in) begin
                bus.dv_out <= 1'b0;
            end

            for (int i = 0; i < N_CHAN; i++) begin
                // A new value arriving as the channel is latched re-arms pend: set beats clear.
                if (ingest_hit[i]) begin
                    data_buf[i] <= sat_data;
                    pend[i]     <= 1'b1;
                end else if (load && gnt[i]) begin
                    pend[i] <= 1'b0;
                end

                // Not an overwrite when the old value is being latched for delivery this cycle.
                if (ingest_hit[i] && pend[i] && !(load && gnt[i])) begin
                    ovf[i] <= 1'b1;
                end else if (ovfc_wr && bus.wr_data[i]) begin
                    ovf[i] <= 1'b0;
                end
            end

            if (en_wr) begin
                en <= bus.wr_data[N_CHAN-1:0];
            end
        end
    end

endmodule

// File: tb/tb_chan_out_arbiter.sv
// tb/tb_chan_out_arbiter.sv - self-checking bench for chan_out_arbiter
module tb_chan_out_arbiter;
    import chan_out_arbiter_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    always #5 clk_in = ~clk_in;

    chan_out_arbiter_if bus ();

    chan_out_arbiter dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct {
        logic [W_CHAN-1:0] chan;
        logic [W_DOUT-1:0] data;
    } exp_t;

    typedef struct {
        int                chan;
        longint            din;
        logic [W_DOUT-1:0] exp_data;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted transfer must match the oldest expected entry.
    always @(negedge clk_in) begin
        if (rst_in && bus.dv_out && bus.rdy_in) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_transfer: got chan %0d data 0x%0h, expected no transfer",
                         bus.chan_out, bus.data_out);
            end else begin
                mon_e = sb.pop_front();
                check("sb_transfer", {43'd0, bus.chan_out, bus.data_out}, {43'd0, mon_e.chan, mon_e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input int ch, input logic [W_DOUT-1:0] d);
        exp_t e;
        e.chan = W_CHAN'(ch);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic ingest(input int ch, input longint d);
        bus.dv_in   = 1'b1;
        bus.chan_in = W_CHAN'(ch);
        bus.data_in = W_DIN'(d);
        tick();
        bus.dv_in   = 1'b0;
    endtask

    task automatic cfg(input logic [W_WR_ADDR-1:0] a, input logic [W_WR_DATA-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            tick();
        end
        check(name, 64'(sb.size()), 64'd0);
        tick();
    endtask

    task automatic do_reset();
        rst_in      = 1'b0;
        bus.dv_in   = 1'b0;
        bus.chan_in = '0;
        bus.data_in = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rdy_in  = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1);
    end

    initial begin
        int cnt;

        vecs[0] = '{chan: 2, din: 100,    exp_data: 16'd100};
        vecs[1] = '{chan: 0, din: 70000,  exp_data: 16'h7FFF};
        vecs[2] = '{chan: 0, din: -70000, exp_data: 16'h8000};
        vecs[3] = '{chan: 4, din: -5,     exp_data: 16'hFFFB};
        vecs[4] = '{chan: 3, din: 32767,  exp_data: 16'h7FFF};
        vecs[5] = '{chan: 1, din: -32768, exp_data: 16'h8000};
        vecs[6] = '{chan: 1, din: 32768,  exp_data: 16'h7FFF};
        vecs[7] = '{chan: 3, din: -32769, exp_data: 16'h8000};

        do_reset();
        check("reset_dv_out",   64'(bus.dv_out),   64'd0);
        check("reset_chan_out", 64'(bus.chan_out), 64'd0);
        check("reset_data_out", 64'(bus.data_out), 64'd0);
        check("reset_ovf_out",  64'(bus.ovf_out),  64'd0);

        // Two-cycle latency and one-cycle drop with rdy_in already high.
        bus.rdy_in = 1'b1;
        cfg(ADDR_EN, 48'h1F);
        push(2, 16'd100);
        ingest(2, 100);
        check("lat_dv_low_1st", 64'(bus.dv_out), 64'd0);
        tick();
        check("lat_dv_high",  64'(bus.dv_out),   64'd1);
        check("lat_chan",     64'(bus.chan_out), 64'd2);
        check("lat_data",     64'(bus.data_out), 64'd100);
        tick();
        check("lat_dv_drop",  64'(bus.dv_out),   64'd0);
        check("lat_chan_keep", 64'(bus.chan_out), 64'd2);

        for (int v = 0; v < 8; v++) begin
            push(vecs[v].chan, vecs[v].exp_data);
            ingest(vecs[v].chan, vecs[v].din);
            drain("vec_drain");
        end

        // Backpressure hold with coalescing overwrite on another channel.
        bus.rdy_in = 1'b0;
        push(4, 16'd77);
        ingest(4, 77);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 2) ingest(1, 5);
            else if (i == 5) ingest(1, 9);
            else tick();
            check("hold_stable", {bus.dv_out, 11'd0, bus.chan_out, bus.data_out},
                  {1'b1, 11'd0, 5'd4, 16'd77});
        end
        check("ovf_ch1_set", 64'(bus.ovf_out), 64'h02);
        push(1, 16'd9);
        bus.rdy_in = 1'b1;
        drain("hold_drain");
        cfg(ADDR_OVFC, 48'h02);
        check("ovf_clear", 64'(bus.ovf_out), 64'h00);

        // Round-robin order from reset pointer, then after wrap.
        do_reset();
        bus.rdy_in = 1'b1;
        ingest(4, 40);
        ingest(3, 30);
        ingest(0, 10);
        push(0, 16'd10);
        push(3, 16'd30);
        push(4, 16'd40);
        cfg(ADDR_EN, 48'h1F);
        drain("rr_drain_1");
        cfg(ADDR_EN, 48'h00);
        ingest(4, 41);
        ingest(0, 11);
        push(0, 16'd11);
        push(4, 16'd41);
        cfg(ADDR_EN, 48'h1F);
        drain("rr_drain_2");

        // Same-cycle ingest on the channel being latched: old value first, then new.
        cfg(ADDR_EN, 48'h00);
        ingest(0, 10);
        push(0, 16'd10);
        push(0, 16'd20);
        cfg(ADDR_EN, 48'h01);
        ingest(0, 20);
        check("same_cycle_no_ovf", 64'(bus.ovf_out), 64'h00);
        drain("same_cycle_drain");

        // Disabled channel stays pending; out-of-range channel is dropped.
        do_reset();
        bus.rdy_in = 1'b1;
        ingest(1, 33);
        ingest(7, 99);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.dv_out) cnt++;
        end
        check("disabled_no_send", 64'(cnt), 64'd0);
        check("bad_chan_no_ovf", 64'(bus.ovf_out), 64'h00);
        push(1, 16'd33);
        cfg(ADDR_EN, 48'h02);
        drain("reenable_drain");
        cfg(ADDR_EN, 48'h1F);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.dv_out) cnt++;
        end
        check("bad_chan_dropped", 64'(cnt), 64'd0);

        // Reset in the middle of a stalled transfer.
        bus.rdy_in = 1'b0;
        ingest(3, 11);
        ingest(2, 1);
        ingest(2, 2);
        check("pre_rst_dv",  64'(bus.dv_out),  64'd1);
        check("pre_rst_ovf", 64'(bus.ovf_out), 64'h04);
        rst_in = 1'b0;
        tick();
        check("rst_mid_dv",   64'(bus.dv_out),   64'd0);
        check("rst_mid_ovf",  64'(bus.ovf_out),  64'h00);
        check("rst_mid_data", 64'(bus.data_out), 64'd0);
        rst_in = 1'b1;
        bus.rdy_in = 1'b1;
        cfg(ADDR_EN, 48'h1F);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.dv_out) cnt++;
        end
        check("rst_pend_cleared", 64'(cnt), 64'd0);

        // Overwrite event beats a same-cycle flag clear.
        cfg(ADDR_EN, 48'h00);
        ingest(2, 1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_OVFC;
        bus.wr_data = 48'h1F;
        ingest(2, 2);
        bus.wr_en   = 1'b0;
        check("ovf_set_beats_clear", 64'(bus.ovf_out), 64'h04);
        push(2, 16'd2);
        cfg(ADDR_EN, 48'h1F);
        drain("final_drain");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
